// File: rtl/mem_bus_slave_if.sv
// Bus between one master and a memory slave: strobe, read/write select, the shared
// AddrData lines and slave status. AddrData is driven by whichever side has its enable up.
interface mem_bus_slave_if #(
  parameter int BUSWIDTH = 16
);
  logic                AddrValid;
  logic                rw;
  logic [BUSWIDTH-1:0] mstData;
  logic                mstOe;
  logic [BUSWIDTH-1:0] rdData;
  logic                busy;
  logic                rd_drive;
  logic                err;
  wire  [BUSWIDTH-1:0] AddrData;

  // The slave owns the lines during read beats; otherwise the master may drive or leave them floating.
  assign AddrData = rd_drive ? rdData : (mstOe ? mstData : {BUSWIDTH{1'bz}});

  modport slave (
    input  AddrValid, rw, AddrData,
    output rdData, busy, rd_drive, err
  );

  modport master (
    output AddrValid, rw, mstData, mstOe,
    input  AddrData, busy, rd_drive, err
  );
endinterface

// File: rtl/mem_bus_slave.sv
// Memory-side bus slave: page decode, fixed-length bursts, read wait states and
// protocol-error flagging over its own word-addressed storage.
module mem_bus_slave #(
  parameter int                   BUSWIDTH    = 16,
  parameter int                   DEPTH       = 256,
  parameter int                   PAGE_BITS   = 4,
  parameter logic [PAGE_BITS-1:0] PAGE_ID     = 4'h2,
  parameter int                   BURST_LEN   = 4,
  parameter int                   WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            resetL,
  mem_bus_slave_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [4:0] BEAT_LAST = 5'(BURST_LEN - 1);
  localparam logic [2:0] WAIT_LAST = 3'((WAIT_STATES > 32'sd0) ? (WAIT_STATES - 1) : 0);
  localparam logic       NO_WAIT   = (WAIT_STATES == 32'sd0);

  logic [1:0]          state;
  logic [1:0]          stateNext;
  logic [ADDR_W-1:0]   addrQ;
  logic [ADDR_W-1:0]   addrNext;
  logic [4:0]          beatCnt;
  logic [4:0]          beatNext;
  logic [2:0]          waitCnt;
  logic [2:0]          waitNext;
  logic                errQ;
  logic                pageMatch;
  logic                lastBeat;
  logic [BUSWIDTH-1:0] mem [DEPTH];

  assign pageMatch = (bus.AddrData[BUSWIDTH-1 -: PAGE_BITS] == PAGE_ID);
  assign lastBeat  = (beatCnt == BEAT_LAST);

  // Next-state, burst address and beat/wait counter logic.
  always_comb begin
    stateNext = state;
    addrNext  = addrQ;
    beatNext  = beatCnt;
    waitNext  = waitCnt;
    case (state)
      S_IDLE: begin
        if (bus.AddrValid && pageMatch) begin
          addrNext = bus.AddrData[ADDR_W-1:0];
          beatNext = 5'd0;
          waitNext = 3'd0;
          if (!bus.rw) begin
            stateNext = S_WRITE;
          end else if (NO_WAIT) begin
            stateNext = S_READ;
          end else begin
            stateNext = S_WAIT;
          end
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_WAIT: begin
        waitNext = waitCnt + 3'd1;
        if (waitCnt == WAIT_LAST) begin
          stateNext = S_READ;
        end else begin
          stateNext = S_WAIT;
        end
      end
      S_READ, S_WRITE: begin
        // Address wraps naturally at DEPTH because addrQ is exactly log2(DEPTH) wide.
        addrNext = addrQ + ADDR_W'(1);
        beatNext = beatCnt + 5'd1;
        if (lastBeat) begin
          stateNext = S_IDLE;
        end else begin
          stateNext = state;
        end
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // Control registers; a strobe for this page while a burst is running is flagged one cycle later.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state   <= S_IDLE;
      addrQ   <= '0;
      beatCnt <= 5'd0;
      waitCnt <= 3'd0;
      errQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      addrQ   <= addrNext;
      beatCnt <= beatNext;
      waitCnt <= waitNext;
      errQ    <= bus.AddrValid && pageMatch && (state != S_IDLE);
    end
  end

  // Storage is deliberately left out of reset so beats written before a reset survive it.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) begin
      mem[addrQ] <= bus.AddrData;
    end
  end

  assign bus.rdData   = mem[addrQ];
  assign bus.busy     = (state != S_IDLE);
  assign bus.rd_drive = (state == S_READ);
  assign bus.err      = errQ;
endmodule

// File: tb/tb_mem_bus_slave.sv
// Bench for mem_bus_slave: a directed transaction table, a reset-abort sequence and
// random bursts against a reference memory, on a default instance and a waited instance.
module tb_mem_bus_slave;
  localparam int W = 16;

  typedef struct packed {
    logic             sel;
    logic             isRead;
    logic [15:0]      addr;
    logic [3:0][15:0] beats;
    logic [2:0]       errAt;
    logic [15:0]      errAddr;
  } vec_t;

  logic clk = 1'b0;
  logic resetL = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic         av   [2];
  logic         rwIn [2];
  logic         oe   [2];
  logic [W-1:0] dat  [2];
  logic [W-1:0] refMem [2][256];
  bit           known  [2][256];
  vec_t         vecs [14];

  always #5 clk = ~clk;

  mem_bus_slave_if #(.BUSWIDTH(W)) bus0 ();
  mem_bus_slave_if #(.BUSWIDTH(W)) bus1 ();

  assign bus0.AddrValid = av[0];
  assign bus0.rw        = rwIn[0];
  assign bus0.mstOe     = oe[0];
  assign bus0.mstData   = dat[0];
  assign bus1.AddrValid = av[1];
  assign bus1.rw        = rwIn[1];
  assign bus1.mstOe     = oe[1];
  assign bus1.mstData   = dat[1];

  mem_bus_slave #(.BUSWIDTH(W), .DEPTH(256), .PAGE_BITS(4), .PAGE_ID(4'h2),
                  .BURST_LEN(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .resetL(resetL), .bus(bus0.slave));

  mem_bus_slave #(.BUSWIDTH(W), .DEPTH(256), .PAGE_BITS(4), .PAGE_ID(4'h2),
                  .BURST_LEN(2), .WAIT_STATES(3)) dut1 (
    .clk(clk), .resetL(resetL), .bus(bus1.slave));

  function automatic logic [2:0] flags(input logic s);
    return s ? {bus1.busy, bus1.rd_drive, bus1.err} : {bus0.busy, bus0.rd_drive, bus0.err};
  endfunction

  function automatic logic [W-1:0] busData(input logic s);
    return s ? bus1.AddrData : bus0.AddrData;
  endfunction

  function automatic vec_t mk(input logic sel, input logic isRead, input logic [15:0] addr,
                              input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] b2, input logic [15:0] b3,
                              input logic [2:0] errAt, input logic [15:0] errAddr);
    vec_t v;
    v.sel = sel; v.isRead = isRead; v.addr = addr;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    v.errAt = errAt; v.errAddr = errAddr;
    return v;
  endfunction

  task automatic checkFlags(input logic s, input string tag, input logic [2:0] exp);
    logic [2:0] act;
    act = flags(s);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d busy/rd_drive/err got %b want %b", tag, s, act, exp);
    end
  endtask

  task automatic checkData(input logic s, input string tag, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = busData(s);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d AddrData got %h want %h", tag, s, act, exp);
    end
  endtask

  // Runs one transaction from its address cycle through one idle cycle after the burst.
  task automatic runTxn(input vec_t v);
    int         ws, bl, n, c;
    logic       s, hit, strobe, expBusy, expDrv, expErr;
    logic [W-1:0] drv;
    logic [7:0]   idx;
    s   = v.sel;
    ws  = s ? 3 : 0;
    bl  = s ? 2 : 4;
    n   = v.isRead ? ws + bl : bl;
    hit = (v.addr[15:12] == 4'h2);
    av[s] = 1'b1; rwIn[s] = v.isRead; oe[s] = 1'b1; dat[s] = v.addr;
    @(negedge clk);
    checkFlags(s, "addr cycle", 3'b000);
    @(posedge clk); #1;
    for (c = 1; c <= n + 1; c++) begin
      strobe  = (c == int'(v.errAt));
      av[s]   = strobe;
      rwIn[s] = 1'($urandom);
      oe[s]   = (!v.isRead && c <= n) || strobe;
      if (strobe) drv = v.errAddr;
      else if (!v.isRead && c <= n) drv = v.beats[c-1];
      else drv = 16'($urandom);
      dat[s] = drv;
      @(negedge clk);
      expBusy = hit && (c <= n);
      expDrv  = hit && v.isRead && (c > ws) && (c <= n);
      expErr  = hit && (v.errAt != 3'd0) && (int'(v.errAt) <= n) && (c == int'(v.errAt) + 1)
                && (v.errAddr[15:12] == 4'h2);
      checkFlags(s, v.isRead ? "read cycle" : "write cycle", {expBusy, expDrv, expErr});
      if (expDrv) begin
        idx = 8'(v.addr[7:0] + 8'(c - 1 - ws));
        if (known[s][idx]) checkData(s, "read beat", v.beats[c-1-ws]);
      end
      if (hit && !v.isRead && c <= n) begin
        idx = 8'(v.addr[7:0] + 8'(c - 1));
        refMem[s][idx] = drv;
        known[s][idx]  = 1'b1;
      end
      @(posedge clk); #1;
    end
    av[s] = 1'b0; oe[s] = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    logic [3:0] pg;
    for (int i = 0; i < 2; i++) begin
      av[i] = 1'b0; rwIn[i] = 1'b0; oe[i] = 1'b0; dat[i] = 16'h0000;
      for (int j = 0; j < 256; j++) begin
        known[i][j] = 1'b0; refMem[i][j] = 16'h0000;
      end
    end

    vecs[0]  = mk(1'b0, 1'b0, 16'h2010, 16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4, 3'd0, 16'h0000);
    vecs[1]  = mk(1'b0, 1'b1, 16'h2010, 16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4, 3'd0, 16'h0000);
    vecs[2]  = mk(1'b0, 1'b0, 16'h3010, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd0, 16'h0000);
    vecs[3]  = mk(1'b0, 1'b1, 16'h2010, 16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4, 3'd0, 16'h0000);
    vecs[4]  = mk(1'b0, 1'b0, 16'h20FE, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 3'd0, 16'h0000);
    vecs[5]  = mk(1'b0, 1'b1, 16'h20FE, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 3'd0, 16'h0000);
    vecs[6]  = mk(1'b0, 1'b0, 16'h2000, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 3'd2, 16'h2000);
    vecs[7]  = mk(1'b0, 1'b1, 16'h2000, 16'h0011, 16'h2000, 16'h0033, 16'h0044, 3'd0, 16'h0000);
    vecs[8]  = mk(1'b0, 1'b0, 16'h2040, 16'h005A, 16'h006B, 16'h007C, 16'h008D, 3'd4, 16'h2100);
    vecs[9]  = mk(1'b0, 1'b1, 16'h2040, 16'h005A, 16'h006B, 16'h007C, 16'h2100, 3'd0, 16'h0000);
    vecs[10] = mk(1'b1, 1'b0, 16'h2010, 16'h0055, 16'h0066, 16'h0000, 16'h0000, 3'd0, 16'h0000);
    vecs[11] = mk(1'b1, 1'b1, 16'h2010, 16'h0055, 16'h0066, 16'h0000, 16'h0000, 3'd0, 16'h0000);
    vecs[12] = mk(1'b0, 1'b0, 16'h2A20, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 3'd3, 16'h3000);
    vecs[13] = mk(1'b0, 1'b1, 16'h2020, 16'h0001, 16'h0002, 16'h3000, 16'h0004, 3'd0, 16'h0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkFlags(1'b0, "in reset", 3'b000);
    checkFlags(1'b1, "in reset", 3'b000);
    @(posedge clk); #1;
    resetL = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) runTxn(vecs[i]);

    // Reset asserted during the second read beat, then the same burst is read again.
    av[0] = 1'b1; rwIn[0] = 1'b1; oe[0] = 1'b1; dat[0] = 16'h2040;
    @(posedge clk); #1;
    av[0] = 1'b0; oe[0] = 1'b0;
    @(negedge clk);
    checkFlags(1'b0, "pre-reset beat0", 3'b110);
    checkData(1'b0, "pre-reset beat0", 16'h005A);
    @(posedge clk); #1;
    resetL = 1'b0; #1;
    checkFlags(1'b0, "reset mid-read", 3'b000);
    @(posedge clk); #1;
    resetL = 1'b1;
    @(negedge clk);
    checkFlags(1'b0, "after reset", 3'b000);
    @(posedge clk); #1;
    runTxn(vecs[9]);

    for (int t = 0; t < 150; t++) begin
      v = '0;
      v.sel    = 1'($urandom);
      v.isRead = 1'($urandom);
      pg       = ($urandom_range(0, 4) == 0) ? 4'h3 : 4'h2;
      v.addr   = {pg, 4'($urandom), ($urandom_range(0, 1) == 0) ?
                  8'($urandom_range(0, 15)) : 8'($urandom_range(248, 255))};
      n = v.sel ? 2 : 4;
      for (int k = 0; k < 4; k++) begin
        if (v.isRead) v.beats[k] = refMem[v.sel][8'(v.addr[7:0] + 8'(k))];
        else v.beats[k] = 16'($urandom);
      end
      if (!v.isRead && pg == 4'h2 && $urandom_range(0, 3) == 0) begin
        v.errAt   = 3'($urandom_range(1, n));
        v.errAddr = {4'($urandom_range(2, 3)), 12'($urandom)};
      end
      runTxn(v);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
